// File: rtl/dmem_write_buffer_pkg.sv
// Shared defaults and types for the posted-store write buffer between the
// mips32 memory stage and dmem.
package dmem_write_buffer_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int WORD_LSB  = 2;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] adr;
    logic [WIDTH_DEF-1:0] wd;
  } wb_entry_t;

  function automatic logic [WIDTH_DEF-1:WORD_LSB] word_of(input logic [WIDTH_DEF-1:0] a);
    return a[WIDTH_DEF-1:WORD_LSB];
  endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Core-side and dmem-side signals of the write buffer; the buffer is the slave.
interface dmem_write_buffer_if #(
  parameter int WIDTH = 32
);

  logic             cpu_we;
  logic             cpu_re;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             cpu_stall;
  logic             flush;
  logic             empty;
  logic             mem_we;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  modport slave (
    input  cpu_we, cpu_re, cpu_adr, cpu_wd, flush, mem_rd,
    output cpu_rd, cpu_stall, empty, mem_we, mem_adr, mem_wd
  );

  modport master (
    output cpu_we, cpu_re, cpu_adr, cpu_wd, flush, mem_rd,
    input  cpu_rd, cpu_stall, empty, mem_we, mem_adr, mem_wd
  );

endinterface

// File: rtl/dmem_write_buffer_fifo.sv
// Circular store queue: address/data/valid arrays with head, tail and count.
// The whole array is exposed so the top can search it for forwarding.
module dmem_write_buffer_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int PTRBITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            push_adr_i,
  input  logic [WIDTH-1:0]            push_wd_i,
  output logic [DEPTH-1:0][WIDTH-1:0] adr_o,
  output logic [DEPTH-1:0][WIDTH-1:0] wd_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [PTRBITS-1:0]          head_o,
  output logic [PTRBITS:0]            count_o
);

  logic [PTRBITS-1:0]          head_q, head_d;
  logic [PTRBITS-1:0]          tail_q, tail_d;
  logic [PTRBITS:0]            count_q, count_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] adr_q;
  logic [DEPTH-1:0][WIDTH-1:0] wd_q;

  // When full, push and pop hit the same slot: clear first, then refill.
  always_comb begin
    head_d  = head_q + PTRBITS'(pop_i);
    tail_d  = tail_q + PTRBITS'(push_i);
    count_d = count_q + {{PTRBITS{1'b0}}, push_i} - {{PTRBITS{1'b0}}, pop_i};
    valid_d = valid_q;
    if (pop_i)  valid_d[head_q] = 1'b0;
    if (push_i) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      adr_q[tail_q] <= push_adr_i;
      wd_q[tail_q]  <= push_wd_i;
    end
  end

  assign adr_o   = adr_q;
  assign wd_o    = wd_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer: stores retire in one cycle and drain to dmem on idle
// port cycles; loads get the youngest pending match or fall through to dmem.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PTRBITS = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  dmem_write_buffer_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] adr;
  logic [DEPTH-1:0][WIDTH-1:0] wd;
  logic [DEPTH-1:0]            valid;
  logic [PTRBITS-1:0]          head;
  logic [PTRBITS:0]            count;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic                        fwd_hit;
  logic [WIDTH-1:0]            fwd_wd;
  logic [PTRBITS-1:0]          fwd_idx;
  logic                        unused_flush;

  dmem_write_buffer_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PTRBITS(PTRBITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .push_adr_i(bus.cpu_adr),
    .push_wd_i (bus.cpu_wd),
    .adr_o     (adr),
    .wd_o      (wd),
    .valid_o   (valid),
    .head_o    (head),
    .count_o   (count)
  );

  // Drain is purely opportunistic, so flush needs no logic of its own.
  assign unused_flush = bus.flush;

  assign empty = (count == '0);
  assign pop   = !empty && !bus.cpu_re;
  assign push  = bus.cpu_we && ((count < (PTRBITS+1)'(DEPTH)) || pop);

  assign bus.empty     = empty;
  assign bus.mem_we    = pop;
  assign bus.cpu_stall = bus.cpu_we && !push;
  assign bus.mem_adr   = !reset ? '0 : (bus.cpu_re ? bus.cpu_adr : adr[head]);
  assign bus.mem_wd    = !reset ? '0 : wd[head];

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_wd  = '0;
    fwd_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTRBITS'(k);
      if (valid[fwd_idx] &&
          (adr[fwd_idx][WIDTH-1:WORD_LSB] == bus.cpu_adr[WIDTH-1:WORD_LSB])) begin
        fwd_hit = 1'b1;
        fwd_wd  = wd[fwd_idx];
      end
    end
  end

  assign bus.cpu_rd = fwd_hit ? fwd_wd : bus.mem_rd;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed vector table, multi-cycle corner
// sequences and random traffic against a queue-based reference model.
module tb_dmem_write_buffer;
  import dmem_write_buffer_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_write_buffer_if #(.WIDTH(W)) bus ();

  dmem_write_buffer #(.WIDTH(W), .DEPTH(D), .PTRBITS(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  wb_entry_t mq[$];
  wb_entry_t wlog[$];
  logic e_mwe, e_push;

  typedef struct {
    logic        we, re;
    logic [31:0] adr, wd, mrd;
    logic        stall, mwe;
    logic [31:0] madr, mwd;
    logic        empty;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[24];

  always @(posedge clk)
    if (reset && bus.mem_we) wlog.push_back('{adr: bus.mem_adr, wd: bus.mem_wd});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [31:0] a, input logic [31:0] mrd);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (word_of(mq[i].adr) == word_of(a)) return mq[i].wd;
    return mrd;
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [31:0] mrd, input logic fl);
    bus.cpu_we  = we;
    bus.cpu_re  = re;
    bus.cpu_adr = adr;
    bus.cpu_wd  = wd;
    bus.mem_rd  = mrd;
    bus.flush   = fl;
    #4;
  endtask

  task automatic model_check();
    e_mwe  = (mq.size() != 0) && !bus.cpu_re;
    e_push = bus.cpu_we && ((mq.size() < D) || e_mwe);
    check("m_empty", bus.empty, mq.size() == 0);
    check("m_mem_we", bus.mem_we, e_mwe);
    check("m_stall", bus.cpu_stall, bus.cpu_we && !e_push);
    if (bus.cpu_re) begin
      check("m_mem_adr_ld", bus.mem_adr, bus.cpu_adr);
      check("m_cpu_rd", bus.cpu_rd, m_fwd(bus.cpu_adr, bus.mem_rd));
    end else if (e_mwe) begin
      check("m_mem_adr", bus.mem_adr, mq[0].adr);
      check("m_mem_wd", bus.mem_wd, mq[0].wd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_mwe) void'(mq.pop_front());
    if (e_push) mq.push_back('{adr: bus.cpu_adr, wd: bus.cpu_wd});
    #1;
  endtask

  task automatic cyc(input logic we, input logic re, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [31:0] mrd, input logic fl);
    drive(we, re, adr, wd, mrd, fl);
    model_check();
    tick();
  endtask

  initial begin
    int n;
    // we, re, adr, wd, mrd | stall, mwe, madr, mwd, empty, rd
    tbl[0]  = '{1, 0, 252, 210, 0,           0, 0, 0,   0,    1, 0};
    tbl[1]  = '{0, 0, 0,   0,   0,           0, 1, 252, 210,  0, 0};
    tbl[2]  = '{0, 0, 0,   0,   0,           0, 0, 0,   0,    1, 0};
    tbl[3]  = '{1, 0, 252, 5,   0,           0, 0, 0,   0,    1, 0};
    tbl[4]  = '{1, 1, 252, 7,   32'hdead,    0, 0, 252, 0,    0, 5};
    tbl[5]  = '{0, 1, 252, 0,   32'hdead,    0, 0, 252, 0,    0, 7};
    tbl[6]  = '{0, 0, 0,   0,   0,           0, 1, 252, 5,    0, 0};
    tbl[7]  = '{0, 0, 0,   0,   0,           0, 1, 252, 7,    0, 0};
    tbl[8]  = '{0, 0, 0,   0,   0,           0, 0, 0,   0,    1, 0};
    tbl[9]  = '{1, 1, 0,   32'ha0, 32'h1234, 0, 0, 0,   0,    1, 32'h1234};
    tbl[10] = '{1, 1, 4,   32'ha4, 32'h1234, 0, 0, 4,   0,    0, 32'h1234};
    tbl[11] = '{1, 1, 8,   32'ha8, 32'h1234, 0, 0, 8,   0,    0, 32'h1234};
    tbl[12] = '{1, 1, 12,  32'hac, 32'h1234, 0, 0, 12,  0,    0, 32'h1234};
    tbl[13] = '{1, 1, 16,  32'hb0, 32'h1234, 1, 0, 16,  0,    0, 32'h1234};
    tbl[14] = '{1, 0, 16,  32'hb0, 0,        0, 1, 0,   32'ha0, 0, 0};
    tbl[15] = '{0, 0, 0,   0,   0,           0, 1, 4,   32'ha4, 0, 0};
    tbl[16] = '{0, 0, 0,   0,   0,           0, 1, 8,   32'ha8, 0, 0};
    tbl[17] = '{0, 0, 0,   0,   0,           0, 1, 12,  32'hac, 0, 0};
    tbl[18] = '{0, 0, 0,   0,   0,           0, 1, 16,  32'hb0, 0, 0};
    tbl[19] = '{0, 0, 0,   0,   0,           0, 0, 0,   0,    1, 0};
    tbl[20] = '{1, 0, 40,  32'h40, 0,        0, 0, 0,   0,    1, 0};
    tbl[21] = '{0, 1, 100, 0,   32'h5555,    0, 0, 100, 0,    0, 32'h5555};
    tbl[22] = '{0, 0, 0,   0,   0,           0, 1, 40,  32'h40, 0, 0};
    tbl[23] = '{0, 0, 0,   0,   0,           0, 0, 0,   0,    1, 0};

    // Reset held with a store and a load requested.
    drive(1, 1, 32'h44, 32'h99, 32'h77, 0);
    #8;
    check("rst_empty", bus.empty, 1'b1);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_stall", bus.cpu_stall, 1'b0);
    check("rst_mem_adr", bus.mem_adr, 32'h0);
    check("rst_mem_wd", bus.mem_wd, 32'h0);
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].adr, tbl[i].wd, tbl[i].mrd, 0);
      check($sformatf("v%0d_stall", i), bus.cpu_stall, tbl[i].stall);
      check($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].mwe);
      check($sformatf("v%0d_empty", i), bus.empty, tbl[i].empty);
      if (tbl[i].mwe || tbl[i].re) check($sformatf("v%0d_mem_adr", i), bus.mem_adr, tbl[i].madr);
      if (tbl[i].mwe) check($sformatf("v%0d_mem_wd", i), bus.mem_wd, tbl[i].mwd);
      if (tbl[i].re) check($sformatf("v%0d_cpu_rd", i), bus.cpu_rd, tbl[i].rd);
      model_check();
      tick();
    end

    // Reset while three stores are pending: none may reach dmem.
    cyc(1, 1, 32'h200, 32'h11, 0, 0);
    cyc(1, 1, 32'h204, 32'h22, 0, 0);
    cyc(1, 1, 32'h208, 32'h33, 0, 0);
    n = wlog.size();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_empty", bus.empty, 1'b1);
    check("mid_rst_mem_we", bus.mem_we, 1'b0);
    check("mid_rst_mem_adr", bus.mem_adr, 32'h0);
    check("mid_rst_mem_wd", bus.mem_wd, 32'h0);
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    check("mid_rst_no_writes", wlog.size() - n, 0);

    // Ten stores with idle gaps, wrapping the pointers.
    n = wlog.size();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 4 * i, i, 0, 0);
      for (int g = 0; g < i % 3; g++) cyc(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
    check("wrap_count", wlog.size() - n, 10);
    for (int i = 0; i < 10 && n + i < wlog.size(); i++) begin
      check($sformatf("wrap_adr%0d", i), wlog[n + i].adr, 4 * i);
      check($sformatf("wrap_wd%0d", i), wlog[n + i].wd, i);
    end
    check("wrap_empty", bus.empty, 1'b1);

    // Random traffic on a small address set to force duplicates and hits.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 7) * 4,
          $urandom, $urandom, $urandom_range(0, 1));

    // Flush: idle with flush high until the buffer drains, bounded.
    n = 0;
    while (mq.size() != 0 && n < 20) begin
      cyc(0, 0, 0, 0, 0, 1);
      n++;
    end
    drive(0, 0, 0, 0, 0, 1);
    check("flush_model_drained", mq.size(), 0);
    check("flush_empty", bus.empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
